// File: rtl/mem_stage_sized_if.sv
// mem_stage_sized_if: E-stage inputs, pipeline control and M-stage outputs of the memory stage.
interface mem_stage_sized_if #(parameter int REG_W = 5);
  logic stall_m, flush_m;
  logic reg_write_e, memto_reg_e, mem_write_e, mem_signed_e;
  logic [1:0] mem_size_e;
  logic [31:0] alu_out_e, write_data_e;
  logic [REG_W-1:0] write_reg_e;
  logic reg_write_m, memto_reg_m, busy_m, misalign_m;
  logic [31:0] alu_out_m, rd;
  logic [REG_W-1:0] write_reg_m;
  modport master (
    output stall_m, flush_m, reg_write_e, memto_reg_e, mem_write_e, mem_signed_e,
           mem_size_e, alu_out_e, write_data_e, write_reg_e,
    input  reg_write_m, memto_reg_m, busy_m, misalign_m, alu_out_m, rd, write_reg_m
  );
  modport slave (
    input  stall_m, flush_m, reg_write_e, memto_reg_e, mem_write_e, mem_signed_e,
           mem_size_e, alu_out_e, write_data_e, write_reg_e,
    output reg_write_m, memto_reg_m, busy_m, misalign_m, alu_out_m, rd, write_reg_m
  );
endinterface

// File: rtl/mem_stage_sized.sv
// mem_stage_sized: M pipeline register, byte/half/word data memory and load wait-state FSM.
module mem_stage_sized #(
  parameter int DEPTH  = 256,
  parameter int REG_W  = 5,
  parameter int RD_LAT = 0
) (
  input logic clk,
  input logic rst,
  mem_stage_sized_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic rw_q, mtr_q, mw_q, sgn_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wd_q;
  logic [REG_W-1:0] wr_q;
  logic [31:0] mem [DEPTH];
  logic mis, busy, we;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] wword, word, shifted, lane;
  always_comb begin
    mis = (size_q == 2'b11) | ((size_q == 2'b01) & addr_q[0]) | ((size_q == 2'b10) & (|addr_q[1:0]));
    busy = mtr_q & ~mis & (cnt_q != 3'(RD_LAT));
    cnt_d = busy ? ((state_q == IDLE) ? 3'd1 : cnt_q + 3'd1) : 3'd0;
    state_d = busy ? WAIT : IDLE;
    idx = addr_q[AW+1:2];
    word = mem[idx];
    shifted = word >> {addr_q[1:0], 3'b000};
    lane = (size_q == 2'b00) ? {{24{sgn_q & shifted[7]}}, shifted[7:0]}
         : (size_q == 2'b01) ? {{16{sgn_q & shifted[15]}}, shifted[15:0]} : word;
    be = (size_q == 2'b00) ? 4'b0001 << addr_q[1:0]
       : (size_q == 2'b01) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wword = (size_q == 2'b00) ? {4{wd_q[7:0]}} : (size_q == 2'b01) ? {2{wd_q[15:0]}} : wd_q;
    we = mw_q & ~mis;
  end
  // Flush wins over stall; a pending load wait freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      {rw_q, mtr_q, mw_q, sgn_q} <= '0;
      size_q <= '0;
      addr_q <= '0;
      wd_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (!busy && (bus.flush_m || !bus.stall_m)) begin
        rw_q <= bus.reg_write_e & ~bus.flush_m;
        mtr_q <= bus.memto_reg_e & ~bus.flush_m;
        mw_q <= bus.mem_write_e & ~bus.flush_m;
        sgn_q <= bus.mem_signed_e;
        size_q <= bus.mem_size_e;
        addr_q <= bus.alu_out_e;
        wd_q <= bus.write_data_e;
        wr_q <= bus.write_reg_e;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we && !rst)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
  end
  assign bus.reg_write_m = rw_q & ~(mtr_q & mis);
  assign bus.memto_reg_m = mtr_q;
  assign bus.alu_out_m = addr_q;
  assign bus.write_reg_m = wr_q;
  assign bus.busy_m = busy;
  assign bus.misalign_m = mis;
  assign bus.rd = (mtr_q & ~mis & ~busy) ? lane : 32'd0;
endmodule

// File: tb/tb_mem_stage_sized.sv
// tb_mem_stage_sized: directed and random loads/stores checked against a byte-array memory model.
module tb_mem_stage_sized;
  localparam int DEPTH = 64;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [7:0] mb [256];
  mem_stage_sized_if #(.REG_W(5)) bus ();
  mem_stage_sized #(.DEPTH(DEPTH), .REG_W(5), .RD_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic rw, input logic mtr, input logic mw, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] d,
                     input logic [4:0] wr, input logic st, input logic fl);
    bus.reg_write_e = rw;
    bus.memto_reg_e = mtr;
    bus.mem_write_e = mw;
    bus.mem_size_e = sz;
    bus.mem_signed_e = sg;
    bus.alu_out_e = a;
    bus.write_data_e = d;
    bus.write_reg_e = wr;
    bus.stall_m = st;
    bus.flush_m = fl;
  endtask

  function automatic logic mis_f(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ld_f(input logic [1:0] s, input logic sg, input logic [31:0] a);
    logic [7:0] p, b0, b1, b2, b3;
    p = a[7:0];
    b0 = mb[p];
    b1 = mb[8'(p + 8'd1)];
    b2 = mb[8'(p + 8'd2)];
    b3 = mb[8'(p + 8'd3)];
    if (s == 2'b00) return sg ? {{24{b0[7]}}, b0} : {24'd0, b0};
    if (s == 2'b01) return sg ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
    return {b3, b2, b1, b0};
  endfunction

  // One access through M: checks address/misalign, then the load wait and result or store effect.
  task automatic op(input logic is_ld, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                    input logic [31:0] d, input logic [4:0] wr);
    logic m;
    m = mis_f(sz, a);
    drv(is_ld, is_ld, ~is_ld, sz, sg, a, d, wr, 1'b0, 1'b0);
    tick();
    chk("alu_out", bus.alu_out_m, a);
    chk("write_reg", 32'(bus.write_reg_m), 32'(wr));
    chkb("misalign", bus.misalign_m, m);
    if (is_ld && !m) begin
      for (int i = 0; i < LAT; i++) begin
        chkb("busy_wait", bus.busy_m, 1'b1);
        chk("rd_wait", bus.rd, 32'd0);
        chk("hold_addr", bus.alu_out_m, a);
        drv(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
            $urandom, 5'($urandom), 1'($urandom), (i == 0) ? 1'b1 : 1'($urandom));
        tick();
      end
      chkb("busy_done", bus.busy_m, 1'b0);
      chkb("memto_reg", bus.memto_reg_m, 1'b1);
      chkb("reg_write_ld", bus.reg_write_m, 1'b1);
      chk("rd_load", bus.rd, ld_f(sz, sg, a));
    end else begin
      chkb("busy_none", bus.busy_m, 1'b0);
      chk("rd_none", bus.rd, 32'd0);
      chkb("reg_write_nold", bus.reg_write_m, 1'b0);
      if (!is_ld && !m)
        for (int i = 0; i < (sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4); i++)
          mb[8'(a[7:0] + 8'(i))] = d[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] a, x;
    logic [1:0] s;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    #12;
    chkb("rst_reg_write", bus.reg_write_m, 1'b0);
    chkb("rst_memto_reg", bus.memto_reg_m, 1'b0);
    chk("rst_alu_out", bus.alu_out_m, 32'd0);
    chk("rst_write_reg", 32'(bus.write_reg_m), 32'd0);
    chkb("rst_busy", bus.busy_m, 1'b0);
    chk("rst_rd", bus.rd, 32'd0);
    chkb("rst_misalign", bus.misalign_m, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) op(1'b0, 2'b10, 1'b0, 32'(i * 4), $urandom, 5'd0);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 5'd3);
    chk("word_load", bus.rd, 32'hDEADBEEF);
    op(1'b0, 2'b00, 1'b0, 32'h13, 32'h80, 5'd0);
    op(1'b1, 2'b00, 1'b1, 32'h13, 32'd0, 5'd4);
    chk("byte_signed", bus.rd, 32'hFFFFFF80);
    op(1'b1, 2'b00, 1'b0, 32'h13, 32'd0, 5'd4);
    chk("byte_unsigned", bus.rd, 32'h00000080);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 5'd5);
    chk("word_after_byte", bus.rd, 32'h80ADBEEF);
    op(1'b0, 2'b01, 1'b0, 32'h11, 32'h1234, 5'd0);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 5'd6);
    chk("mis_store_nowrite", bus.rd, 32'h80ADBEEF);
    op(1'b1, 2'b10, 1'b0, 32'h12, 32'd0, 5'd7);
    chkb("mis_load_flag", bus.misalign_m, 1'b1);
    op(1'b1, 2'b10, 1'b0, 32'h310, 32'd0, 5'd8);
    chk("addr_wrap", bus.rd, 32'h80ADBEEF);
    drv(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 5'd9, 1'b1, 1'b1);
    tick();
    chkb("flush_reg_write", bus.reg_write_m, 1'b0);
    chkb("flush_memto_reg", bus.memto_reg_m, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 5'd9, 1'b1, 1'b0);
    tick();
    chk("stall_hold", bus.alu_out_m, 32'h10);
    chkb("stall_memto_reg", bus.memto_reg_m, 1'b0);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 5'd10);
    chk("flush_nowrite", bus.rd, 32'h80ADBEEF);
    x = $urandom;
    op(1'b0, 2'b10, 1'b0, 32'h20, x, 5'd0);
    for (int i = 0; i < 2; i++) begin
      drv(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h64, 32'h0, 5'd0, 1'b1, 1'b0);
      tick();
      chk("stall_store_hold", bus.alu_out_m, 32'h20);
    end
    op(1'b1, 2'b10, 1'b0, 32'h20, 32'd0, 5'd11);
    chk("stalled_store", bus.rd, x);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5'd12, 1'b0, 1'b0);
    tick();
    drv(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chkb("pre_rst_busy", bus.busy_m, 1'b1);
    rst = 1'b1;
    #1;
    chkb("midrst_busy", bus.busy_m, 1'b0);
    chk("midrst_rd", bus.rd, 32'd0);
    chkb("midrst_reg_write", bus.reg_write_m, 1'b0);
    chkb("midrst_memto_reg", bus.memto_reg_m, 1'b0);
    chk("midrst_alu_out", bus.alu_out_m, 32'd0);
    chk("midrst_write_reg", 32'(bus.write_reg_m), 32'd0);
    chkb("midrst_misalign", bus.misalign_m, 1'b0);
    rst = 1'b0;
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 5'd13);
    chk("post_rst_load", bus.rd, 32'h80ADBEEF);
    for (int n = 0; n < 150; n++) begin
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (s == 2'b00) ? a[1:0] : (s == 2'b01) ? {a[1], 1'b0} : 2'b00;
      op(1'($urandom), s, 1'($urandom), a, $urandom, 5'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
